// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer for the 16-bit hardwired CPU: owns PC, AR and IR, walks T0..T3,
// and hands the decoded instruction to execute over a valid/ack handshake.
module fetch_decode_unit #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ar,
    output logic [2:0]        opcode,
    output logic              indirect,
    output logic              reg_ref,
    output logic              io_ref,
    output logic              valid,
    input  logic              ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {T0, T1, T2, T3, HOLD} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] ir_next;
    logic [ADDR_W-1:0] ar_next, pc_next;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        ir_next    = ir;
        ar_next    = ar;
        pc_next    = pc;
        mem_read   = 1'b0;
        valid      = 1'b0;
        unique case (state)
            T0: begin
                if (!halt) begin
                    ar_next    = pc;
                    state_next = T1;
                end
            end
            T1: begin
                mem_read   = 1'b1;
                ir_next    = mem_data;
                pc_next    = pc + ADDR_W'(1);
                state_next = T2;
            end
            T2: begin
                ar_next = ir[ADDR_W-1:0];
                // Opcode 7 is register/I-O: bit 15 selects the class there, not indirection.
                if (ir[DATA_W-1] && ir[DATA_W-2 -: 3] != 3'b111) state_next = T3;
                else                                            state_next = HOLD;
            end
            T3: begin
                mem_read   = 1'b1;
                ar_next    = mem_data[ADDR_W-1:0];
                state_next = HOLD;
            end
            HOLD: begin
                valid = 1'b1;
                if (ack) begin
                    if (pc_load) pc_next = pc_load_value;
                    state_next = T0;
                end
            end
            default: state_next = T0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= T0;
            pc    <= RESET_PC;
            ar    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ar    <= ar_next;
            ir    <= ir_next;
        end
    end

    assign mem_address = ar;
    assign opcode      = ir[DATA_W-2 -: 3];
    assign indirect    = ir[DATA_W-1];
    assign reg_ref     = (opcode == 3'b111) && !indirect;
    assign io_ref      = (opcode == 3'b111) && indirect;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: a per-instruction reference model predicts each
// handoff (IR, AR, PC, flags, latency, memory reads); a negedge monitor checks what the DUT presents.
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic [11:0] mem_address;
    logic        mem_read;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [11:0] ar;
    logic [2:0]  opcode;
    logic        indirect, reg_ref, io_ref, valid;
    logic        ack, pc_load;
    logic [11:0] pc_load_value;
    logic [11:0] pc;

    logic [15:0] mem [4096];
    assign mem_data = mem[mem_address];

    fetch_decode_unit #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .mem_address(mem_address), .mem_read(mem_read), .mem_data(mem_data),
        .ir(ir), .ar(ar), .opcode(opcode), .indirect(indirect),
        .reg_ref(reg_ref), .io_ref(io_ref), .valid(valid),
        .ack(ack), .pc_load(pc_load), .pc_load_value(pc_load_value), .pc(pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] ir;
        logic [11:0] ar;
        logic [11:0] pc;
        logic [11:0] rd0;
        logic [11:0] rd1;
        bit          is_ind;
        int          start;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] reads[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          issued = 0;
    int          retired = 0;
    logic [11:0] mpc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // One instruction from the point of view of the programmer's model.
    function automatic exp_t model(input logic [11:0] p);
        exp_t e;
        e.ir     = mem[p];
        e.pc     = p + 12'd1;
        e.rd0    = p;
        e.rd1    = '0;
        e.ar     = e.ir[11:0];
        e.is_ind = e.ir[15] && (e.ir[14:12] != 3'b111);
        if (e.is_ind) begin
            e.rd1 = e.ar;
            e.ar  = mem[e.rd1][11:0];
        end
        e.start = 0;
        e.lat   = 0;
        return e;
    endfunction

    // Monitor: checks each handoff at the rising edge of valid and stability while it stays high.
    initial begin
        exp_t cur;
        exp_t e;
        bit   prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reads.delete();
                prev_valid = 1'b0;
            end else begin
                if (mem_read) reads.push_back(mem_address);
                if (valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        cur = e;
                        retired++;
                        check("ir", 32'(ir), 32'(e.ir));
                        check("ar", 32'(ar), 32'(e.ar));
                        check("pc", 32'(pc), 32'(e.pc));
                        check("opcode", 32'(opcode), 32'(e.ir[14:12]));
                        check("indirect", 32'(indirect), 32'(e.ir[15]));
                        check("reg_ref", 32'(reg_ref), 32'(e.ir[14:12] == 3'b111 && !e.ir[15]));
                        check("io_ref", 32'(io_ref), 32'(e.ir[14:12] == 3'b111 && e.ir[15]));
                        check("latency", 32'(cyc - e.start), 32'(e.lat));
                        check("read_count", 32'(reads.size()), e.is_ind ? 32'd2 : 32'd1);
                        if (reads.size() > 0) check("read_addr0", 32'(reads[0]), 32'(e.rd0));
                        if (e.is_ind && reads.size() > 1) check("read_addr1", 32'(reads[1]), 32'(e.rd1));
                    end
                    reads.delete();
                end else if (valid) begin
                    check("hold_ir", 32'(ir), 32'(cur.ir));
                    check("hold_ar", 32'(ar), 32'(cur.ar));
                    check("hold_pc", 32'(pc), 32'(cur.pc));
                    check("hold_mem_read", 32'(mem_read), 32'd0);
                end
                if (valid) check("hold_addr", 32'(mem_address), 32'(cur.ar));
                prev_valid = valid;
            end
        end
    end

    // Called #1 after the edge that put the DUT in T0.
    task automatic run_instr(input int k_halt, input int wait_hold, input bit do_load,
                             input logic [11:0] load_val);
        exp_t e;
        e = model(mpc);
        e.start = cyc;
        e.lat   = k_halt + (e.is_ind ? 4 : 3);
        sb.push_back(e);
        issued++;
        for (int c = 0; c < e.lat; c++) begin
            if (c < k_halt)       halt = 1'b1;
            else if (c == k_halt) halt = 1'b0;
            else                  halt = 1'($urandom);
            ack           = 1'($urandom);
            pc_load       = 1'($urandom);
            pc_load_value = 12'($urandom);
            @(posedge clk); #1;
        end
        ack = 1'b0;
        for (int w = 0; w < wait_hold; w++) begin
            halt          = 1'($urandom);
            pc_load       = 1'($urandom);
            pc_load_value = 12'($urandom);
            @(posedge clk); #1;
        end
        ack           = 1'b1;
        pc_load       = do_load;
        pc_load_value = load_val;
        @(posedge clk); #1;
        ack     = 1'b0;
        pc_load = 1'b0;
        mpc     = do_load ? load_val : e.pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h000] = 16'h4005;
        mem[12'h006] = 16'h7200;
        mem[12'h005] = 16'h8010;
        mem[12'h010] = 16'h0123;
        mem[12'hFFF] = 16'hF3F0;

        rst_n = 1'b0; halt = 1'b0; ack = 1'b0; pc_load = 1'b0; pc_load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_ar", 32'(ar), 32'h000);
        check("rst_ir", 32'(ir), 32'h0000);
        check("rst_flags", {28'd0, opcode, indirect | reg_ref | io_ref}, 32'd0);
        rst_n = 1'b1;
        mpc   = 12'h000;

        run_instr(0, 0, 1'b1, 12'h006);   // direct 4005
        run_instr(0, 10, 1'b1, 12'h005);  // register-ref 7200, long hold, branch to 005
        run_instr(0, 1, 1'b1, 12'hFFF);   // indirect 8010 -> 0123
        run_instr(5, 0, 1'b0, 12'h000);   // stall 5, I/O at FFF, PC wraps
        check("wrap_pc", 32'(mpc), 32'h000);

        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 2) == 0), 12'($urandom));

        // Abandon an instruction in T2 with an asynchronous reset.
        halt = 1'b0; ack = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_pc", 32'(pc), 32'h000);
        check("midrst_ir", 32'(ir), 32'h0000);
        check("midrst_mem_read", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mpc   = 12'h000;
        for (int n = 0; n < 5; n++)
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 0), 12'($urandom));

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("retired_count", 32'(retired), 32'(issued));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
